alu_lane_seq: RTL and testbench

ALU_LANE_SEQ -- requirements
Module: alu_lane_seq

---
 rtl/alu_seq_pkg.sv | 15 +
 rtl/alu_lane_seq_if.sv | 22 ++
 rtl/alu_lane_seq.sv | 113 +++++++++++
 tb/tb_alu_lane_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, flag bit positions and FSM states shared by the lane sequencer.
package alu_seq_pkg;
    localparam logic [2:0] OP_MUL = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SET = 3'b111;
    localparam int FLAG_V = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_e;
    function automatic logic op_ok(input logic [2:0] op);
        return op == OP_MUL || op == OP_SUB || op == OP_ADD || op == OP_SET;
    endfunction
endpackage

// File: rtl/alu_lane_seq_if.sv
// alu_lane_seq_if: instruction and result handshakes of the lane sequencer.
interface alu_lane_seq_if #(parameter int WIDTH = 8, parameter int LANES = 4);
    logic                   in_valid;
    logic                   in_ready;
    logic [2:0]             in_opcode;
    logic [LANES*WIDTH-1:0] in_vec_a;
    logic [LANES*WIDTH-1:0] in_vec_b;
    logic [WIDTH-1:0]       in_scalar_c;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*WIDTH-1:0] out_vec;
    logic [3:0]             out_flags;
    logic                   out_err;
    modport master (
        output in_valid, in_opcode, in_vec_a, in_vec_b, in_scalar_c, out_ready,
        input  in_ready, out_valid, out_vec, out_flags, out_err
    );
    modport slave (
        input  in_valid, in_opcode, in_vec_a, in_vec_b, in_scalar_c, out_ready,
        output in_ready, out_valid, out_vec, out_flags, out_err
    );
endinterface

// File: rtl/alu_lane_seq.sv
// alu_lane_seq: issues a vector instruction one lane per cycle to an external lane ALU.
// Define ALU_LANE_SEQ_PERF_EN to build the completed-instruction counter on perf_ops.
module alu_lane_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 4
) (
    input  logic              clk,
    input  logic              rst,
    alu_lane_seq_if.slave     bus,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [WIDTH-1:0]  alu_c,
    output logic [2:0]        alu_opcode,
    output logic [31:0]       alu_instance,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic [3:0]        alu_flags,
    output logic [15:0]       perf_ops
);
    localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
    state_e                 state_q, state_d;
    logic [LW-1:0]          lane_q, lane_d;
    logic [2:0]             op_q, op_d;
    logic [LANES*WIDTH-1:0] a_q, a_d, b_q, b_d, vec_q, vec_d;
    logic [WIDTH-1:0]       c_q, c_d;
    logic [3:0]             flg_q, flg_d;
    logic                   err_q, err_d;
    logic                   first, last, iss;
    assign first = lane_q == '0;
    assign last  = lane_q == LW'(LANES - 1);
    assign iss   = state_q == S_ISSUE;
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        vec_d   = vec_q;
        flg_d   = flg_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (bus.in_valid) begin
                op_d    = bus.in_opcode;
                a_d     = bus.in_vec_a;
                b_d     = bus.in_vec_b;
                c_d     = bus.in_scalar_c;
                lane_d  = '0;
                vec_d   = '0;
                flg_d   = '0;
                err_d   = !op_ok(bus.in_opcode);
                state_d = op_ok(bus.in_opcode) ? S_ISSUE : S_DONE;
            end
            S_ISSUE: begin
                vec_d[lane_q*WIDTH +: WIDTH] = alu_result;
                // Lane 0 seeds the reduction so Z can be an AND over all lanes.
                flg_d[FLAG_V] = alu_flags[FLAG_V] | (!first & flg_q[FLAG_V]);
                flg_d[FLAG_N] = alu_flags[FLAG_N] | (!first & flg_q[FLAG_N]);
                flg_d[FLAG_Z] = alu_flags[FLAG_Z] & (first | flg_q[FLAG_Z]);
                flg_d[FLAG_C] = alu_flags[FLAG_C] | (!first & flg_q[FLAG_C]);
                lane_d  = last ? '0 : lane_q + 1'b1;
                state_d = last ? S_DONE : S_ISSUE;
            end
            S_DONE: state_d = bus.out_ready ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            lane_q  <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            vec_q   <= '0;
            flg_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            vec_q   <= vec_d;
            flg_q   <= flg_d;
            err_q   <= err_d;
        end
    end
    assign alu_a        = iss ? a_q[lane_q*WIDTH +: WIDTH] : '0;
    assign alu_b        = iss ? b_q[lane_q*WIDTH +: WIDTH] : '0;
    assign alu_c        = iss ? c_q : '0;
    assign alu_opcode   = iss ? op_q : '0;
    assign alu_instance = iss ? 32'(lane_q) : '0;
    assign bus.in_ready  = state_q == S_IDLE;
    assign bus.out_valid = state_q == S_DONE;
    assign bus.out_vec   = vec_q;
    assign bus.out_flags = flg_q;
    assign bus.out_err   = err_q;
`ifdef ALU_LANE_SEQ_PERF_EN
    logic [15:0] perf_q, perf_d;
    assign perf_d = (bus.out_valid && bus.out_ready && perf_q != 16'hFFFF) ? perf_q + 16'd1 : perf_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) perf_q <= '0;
        else perf_q <= perf_d;
    end
    assign perf_ops = perf_q;
`else
    assign perf_ops = '0;
`endif
endmodule

// File: tb/tb_alu_lane_seq.sv
// tb_alu_lane_seq: directed vectors against a lane-level behavioural model of the sequencer.
module tb_alu_lane_seq;
    localparam int W = 8;
    localparam int L = 4;
    logic clk = 0;
    logic rst = 1;
    logic [W-1:0] alu_a, alu_b, alu_c, alu_result;
    logic [2:0] alu_opcode;
    logic [31:0] alu_instance;
    logic [3:0] alu_flags;
    logic [15:0] perf_ops;
    int vec_n = 0;
    int mis_n = 0;
    alu_lane_seq_if #(.WIDTH(W), .LANES(L)) bus();
    alu_lane_seq #(.WIDTH(W), .LANES(L)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_opcode(alu_opcode),
        .alu_instance(alu_instance), .alu_result(alu_result), .alu_flags(alu_flags),
        .perf_ops(perf_ops)
    );
    always #5 clk = ~clk;
    // Reference lane ALU: returns {V, N, Z, C, result}.
    function automatic logic [11:0] lane_alu(input logic [2:0] op, input logic [7:0] a, b, c);
        int sa, sb, p;
        logic [8:0] s;
        logic [7:0] r;
        logic v, cy;
        sa = int'($signed(a));
        sb = int'($signed(b));
        v = 0;
        cy = 0;
        r = c;
        s = '0;
        p = 0;
        case (op)
            3'b010: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; cy = s[8]; v = (sa + sb > 127) || (sa + sb < -128); end
            3'b001: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; cy = s[8]; v = (sa - sb > 127) || (sa - sb < -128); end
            3'b000: begin p = sa * sb; r = p[7:0]; v = (p > 127) || (p < -128); end
            default: r = c;
        endcase
        return {v, r[7], r == 8'd0, cy, r};
    endfunction
    always_comb begin
        {alu_flags, alu_result} = lane_alu(alu_opcode, alu_a, alu_b, alu_c);
    end
    function automatic logic [35:0] model_exec(input logic [2:0] op, input logic [31:0] a, b, input logic [7:0] c);
        logic [31:0] v;
        logic fv, fn, fz, fc;
        logic [11:0] x;
        v = '0; fv = 0; fn = 0; fz = 1; fc = 0;
        for (int i = 0; i < L; i++) begin
            x = lane_alu(op, a[i*8 +: 8], b[i*8 +: 8], c);
            v[i*8 +: 8] = x[7:0];
            fv = fv | x[11]; fn = fn | x[10]; fz = fz & x[9]; fc = fc | x[8];
        end
        return {fv, fn, fz, fc, v};
    endfunction
    // Model phase: 0 idle, 1..L issuing lane phase-1, L+1 result held.
    int m_ph = 0;
    int m_perf = 0;
    logic [31:0] m_vec = '0, m_a = '0, m_b = '0;
    logic [7:0] m_c = '0;
    logic [2:0] m_op = '0;
    logic [3:0] m_flg = '0;
    logic m_err = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph <= 0; m_perf <= 0; m_vec <= '0; m_flg <= '0; m_err <= 0;
        end else if (m_ph == 0) begin
            if (bus.in_valid) begin
                m_op <= bus.in_opcode; m_a <= bus.in_vec_a; m_b <= bus.in_vec_b; m_c <= bus.in_scalar_c;
                if (bus.in_opcode inside {3'b000, 3'b001, 3'b010, 3'b111}) begin
                    {m_flg, m_vec} <= model_exec(bus.in_opcode, bus.in_vec_a, bus.in_vec_b, bus.in_scalar_c);
                    m_err <= 0; m_ph <= 1;
                end else begin
                    m_flg <= '0; m_vec <= '0; m_err <= 1; m_ph <= L + 1;
                end
            end
        end else if (m_ph <= L) m_ph <= m_ph + 1;
        else if (bus.out_ready) begin
            m_ph <= 0;
            if (m_perf < 65535) m_perf <= m_perf + 1;
        end
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_n++;
        if (act !== exp) begin
            mis_n++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    function automatic int exp_perf(input int n);
`ifdef ALU_LANE_SEQ_PERF_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction
    always @(negedge clk) begin
        automatic bit is = m_ph >= 1 && m_ph <= L;
        automatic int k = is ? m_ph - 1 : 0;
        chk("in_ready", 32'(bus.in_ready), 32'(m_ph == 0));
        chk("out_valid", 32'(bus.out_valid), 32'(m_ph == L + 1));
        chk("alu_a", 32'(alu_a), is ? 32'(m_a[k*8 +: 8]) : 0);
        chk("alu_b", 32'(alu_b), is ? 32'(m_b[k*8 +: 8]) : 0);
        chk("alu_c", 32'(alu_c), is ? 32'(m_c) : 0);
        chk("alu_opcode", 32'(alu_opcode), is ? 32'(m_op) : 0);
        chk("alu_instance", alu_instance, 32'(k));
        chk("perf_ops", 32'(perf_ops), 32'(exp_perf(m_perf)));
        if (m_ph == L + 1) begin
            chk("out_vec", bus.out_vec, m_vec);
            chk("out_flags", 32'(bus.out_flags), 32'(m_flg));
            chk("out_err", 32'(bus.out_err), 32'(m_err));
        end
    end
    task automatic issue(input logic [2:0] op, input logic [31:0] a, b, input logic [7:0] c, output int lat);
        int n = 0;
        bus.in_valid = 1; bus.in_opcode = op; bus.in_vec_a = a; bus.in_vec_b = b; bus.in_scalar_c = c;
        while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("accept_wait", 32'(bus.in_ready), 1);
        @(posedge clk); #1;
        bus.in_valid = 0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("done_wait", 32'(bus.out_valid), 1);
    endtask
    task automatic take();
        bus.out_ready = 1;
        @(posedge clk); #1;
        bus.out_ready = 0;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
    initial begin
        int lat;
        int p0;
        logic [31:0] held;
        bus.in_valid = 0; bus.in_opcode = '0; bus.in_vec_a = '0; bus.in_vec_b = '0;
        bus.in_scalar_c = '0; bus.out_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("rst_perf", 32'(perf_ops), 0);
        chk("rst_ready", 32'(bus.in_ready), 1);
        chk("rst_vec", bus.out_vec, 0);
        issue(3'b010, 32'h00FF6432, 32'h00013219, 8'h00, lat);
        chk("add_lat", 32'(lat), 5);
        chk("add_vec", bus.out_vec, 32'h0000964B);
        chk("add_flags31", 32'(bus.out_flags[3:1]), 3'b110);
        chk("add_flags", 32'(bus.out_flags), 4'hD);
        take();
        issue(3'b000, 32'h0132EC0A, 32'h0003030C, 8'h00, lat);
        chk("mul_vec", bus.out_vec, 32'h0096C478);
        chk("mul_flags32", 32'(bus.out_flags[3:2]), 2'b11);
        take();
        issue(3'b111, 32'h12345678, 32'h9ABCDEF0, 8'hCE, lat);
        chk("set_vec", bus.out_vec, 32'hCECECECE);
        chk("set_flags", 32'(bus.out_flags), 4'b0100);
        chk("set_err", 32'(bus.out_err), 0);
        take();
        issue(3'b001, 32'h05807F10, 32'h0601FF10, 8'h00, lat);
        held = bus.out_vec;
        p0 = int'(perf_ops);
        bus.in_valid = 1; bus.in_opcode = 3'b010;
        repeat (3) begin
            @(posedge clk); #1;
            chk("stall_valid", 32'(bus.out_valid), 1);
            chk("stall_ready", 32'(bus.in_ready), 0);
            chk("stall_vec", bus.out_vec, held);
        end
        take();
        bus.in_valid = 0;
        chk("stall_no_accept", 32'(bus.out_valid), 0);
        chk("stall_perf", 32'(perf_ops), 32'(exp_perf(p0 + 1)));
        @(posedge clk); #1;
        chk("stall_idle", 32'(bus.in_ready), 1);
        issue(3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'hFF, lat);
        chk("err_lat", 32'(lat), 1);
        chk("err_flag", 32'(bus.out_err), 1);
        chk("err_vec", bus.out_vec, 0);
        chk("err_flags", 32'(bus.out_flags), 0);
        chk("err_alu", {alu_a, alu_b, alu_c, 5'b0, alu_opcode}, 0);
        take();
        bus.in_valid = 1; bus.in_opcode = 3'b010; bus.in_vec_a = 32'h01020304; bus.in_vec_b = 32'h01010101;
        @(posedge clk); #1;
        bus.in_valid = 0;
        lat = 0;
        while (alu_instance != 2 && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("lane2_wait", alu_instance, 2);
        rst = 1;
        #1;
        chk("rst_mid_valid", 32'(bus.out_valid), 0);
        @(posedge clk); #1 rst = 0;
        #1;
        chk("rst_mid_ready", 32'(bus.in_ready), 1);
        chk("rst_mid_perf", 32'(perf_ops), 0);
        repeat (6) @(posedge clk);
        #1;
        issue(3'b010, 32'h00FF6432, 32'h00013219, 8'h00, lat);
        chk("readd_lat", 32'(lat), 5);
        chk("readd_vec", bus.out_vec, 32'h0000964B);
        take();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_n, mis_n);
        $finish;
    end
endmodule
